// File: rtl/program_loader.sv
// Purpose : streams a program image (count byte, 4-byte big-endian words, XOR checksum) into instruction memory.
// Latency : prog_write pulses for one cycle, in the cycle right after the 4th byte of a word is accepted.
// Backpressure: in_ready is low outside COUNT/DATA/CHECK; an in_valid gap holds all state unchanged.
//
// Ports:
//   clk, clr (async active-low)     clock / reset
//   start                           one-cycle load request, honoured only in IDLE/DONE/ERR
//   in_data/in_valid/in_ready       byte stream handshake
//   prog_write/prog_addr/prog_data  instruction-memory write port (all registered)
//   cpu_clr                         holds the processor in clear until a good load finishes
//   done/error                      registered load outcome flags
module program_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        prog_write,
    output logic [7:0]  prog_addr,
    output logic [31:0] prog_data,
    output logic        cpu_clr,
    output logic        done,
    output logic        error
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        COUNT = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CHECK = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    state_t      state;
    state_t      next_state;

    // Nine bits so that a count byte of 8'h00 can stand for 256 words.
    logic [8:0]  words_left;
    logic [1:0]  byte_idx;
    logic [7:0]  xor_acc;
    logic [23:0] partial;    // first three bytes of the word being assembled
    logic [7:0]  addr_cnt;
    logic        accept;

    assign in_ready = (state == COUNT) || (state == DATA) || (state == CHECK);
    assign accept   = in_valid && in_ready;

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start) next_state = COUNT;
            end
            COUNT: begin
                if (accept) next_state = DATA;
            end
            DATA: begin
                if (accept && (byte_idx == 2'd3)) next_state = WRITE;
            end
            WRITE: begin
                next_state = (words_left == 9'd1) ? CHECK : DATA;
            end
            CHECK: begin
                if (accept) next_state = (in_data == xor_acc) ? DONE : ERR;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            words_left <= '0;
            byte_idx   <= '0;
            xor_acc    <= '0;
            partial    <= '0;
            addr_cnt   <= '0;
            prog_write <= 1'b0;
            prog_addr  <= BASE_ADDR;
            prog_data  <= '0;
            cpu_clr    <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            // Status outputs are registered copies of the state being entered,
            // so they line up exactly with the state register and cannot glitch.
            prog_write <= (next_state == WRITE);
            done       <= (next_state == DONE);
            error      <= (next_state == ERR);
            cpu_clr    <= (next_state != DONE);

            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        xor_acc  <= '0;
                        byte_idx <= '0;
                        addr_cnt <= BASE_ADDR;
                    end
                end
                COUNT: begin
                    if (accept) begin
                        words_left <= (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    end
                end
                DATA: begin
                    if (accept) begin
                        partial  <= {partial[15:0], in_data};
                        xor_acc  <= xor_acc ^ in_data;
                        byte_idx <= byte_idx + 2'd1;
                        // Load the write port as the word completes so it is
                        // presented from registers during the WRITE cycle.
                        if (byte_idx == 2'd3) begin
                            prog_addr <= addr_cnt;
                            prog_data <= {partial, in_data};
                        end
                    end
                end
                WRITE: begin
                    addr_cnt   <= addr_cnt + 8'd1;
                    words_left <= words_left - 9'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;

    logic        clk = 1'b0;
    logic        clr      [2];
    logic        start    [2];
    logic [7:0]  in_data;
    logic        in_valid;
    logic        rdy      [2];
    logic        pw       [2];
    logic [7:0]  pa       [2];
    logic [31:0] pd       [2];
    logic        cc       [2];
    logic        dn       [2];
    logic        er       [2];

    always #5 clk = ~clk;

    program_loader #(.BASE_ADDR(8'h00)) dut0 (
        .clk(clk), .clr(clr[0]), .start(start[0]),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[0]),
        .prog_write(pw[0]), .prog_addr(pa[0]), .prog_data(pd[0]),
        .cpu_clr(cc[0]), .done(dn[0]), .error(er[0])
    );

    program_loader #(.BASE_ADDR(8'hFE)) dut1 (
        .clk(clk), .clr(clr[1]), .start(start[1]),
        .in_data(in_data), .in_valid(in_valid), .in_ready(rdy[1]),
        .prog_write(pw[1]), .prog_addr(pa[1]), .prog_data(pd[1]),
        .cpu_clr(cc[1]), .done(dn[1]), .error(er[1])
    );

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        int         k;
        logic [7:0] cnt;
        int         gap;
        bit         bad;
        logic       exp_done;
        logic       exp_err;
        logic       exp_cc;
    } vec_t;

    wr_t        exp_q [2][$];
    wr_t        mon_e;
    vec_t       tbl [5];
    logic [7:0] fixed_bytes [8];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         stuck = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] base_of(input int k);
        return (k == 0) ? 8'h00 : 8'hFE;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every observed write must match the oldest expected one,
    // including the cycle it was predicted for.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (pw[k] === 1'b1) begin
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("unexpected_write_dut%0d", k), 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[k].pop_front();
                    chk($sformatf("write_addr_dut%0d", k), {24'd0, pa[k]}, {24'd0, mon_e.addr});
                    chk($sformatf("write_data_dut%0d", k), pd[k], mon_e.data);
                    chk($sformatf("write_cycle_dut%0d", k), cyc, mon_e.cyc);
                end
            end
        end
    end

    task automatic pulse_start(input int k);
        start[k] = 1'b1;
        @(posedge clk);
        #1 start[k] = 1'b0;
        @(negedge clk);
        chk("start_done_clear", {31'd0, dn[k]}, 32'd0);
        chk("start_error_clear", {31'd0, er[k]}, 32'd0);
        chk("start_cpu_clr", {31'd0, cc[k]}, 32'd1);
        chk("start_ready", {31'd0, rdy[k]}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Drives one byte after 'gap' idle cycles; returns the cycle number of the
    // accepting edge.
    task automatic send_byte(input int k, input logic [7:0] b, input int gap, output int acc_cyc);
        int t;
        acc_cyc = 0;
        if (stuck) return;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (t >= 100) begin
            chk("ready_timeout", 32'd0, 32'd1);
            stuck    = 1'b1;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    task automatic run_load(input int k, input logic [7:0] cnt, input int gap_max, input bit bad,
                            input bit fixed, input int abort_after, input int start_at,
                            input logic exp_done, input logic exp_err, input logic exp_cc);
        int          nw;
        int          ac;
        logic [7:0]  x;
        logic [7:0]  b;
        logic [7:0]  addr;
        logic [31:0] w;
        wr_t         e;
        nw   = (cnt == 8'h00) ? 256 : int'(cnt);
        x    = 8'h00;
        w    = 32'd0;
        addr = base_of(k);
        pulse_start(k);
        send_byte(k, cnt, $urandom_range(gap_max, 0), ac);
        for (int i = 0; i < nw * 4; i++) begin
            b = (fixed && i < 8) ? fixed_bytes[i] : 8'($urandom);
            x = x ^ b;
            w = {w[23:0], b};
            send_byte(k, b, $urandom_range(gap_max, 0), ac);
            if (i % 4 == 3) begin
                e.addr = addr;
                e.data = w;
                e.cyc  = ac;
                exp_q[k].push_back(e);
                addr = addr + 8'd1;
            end
            if (i == start_at) begin
                start[k] = 1'b1;
                @(posedge clk);
                #1 start[k] = 1'b0;
            end
            if (i + 1 == abort_after) return;
        end
        // A wrong checksum is the correct XOR with a few bits flipped.
        send_byte(k, bad ? (x ^ 8'h09) : x, $urandom_range(gap_max, 0), ac);
        @(negedge clk);
        chk("end_done", {31'd0, dn[k]}, {31'd0, exp_done});
        chk("end_error", {31'd0, er[k]}, {31'd0, exp_err});
        chk("end_cpu_clr", {31'd0, cc[k]}, {31'd0, exp_cc});
        chk("end_ready", {31'd0, rdy[k]}, 32'd0);
        chk("end_writes_pending", exp_q[k].size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input int k);
        chk("rst_ready", {31'd0, rdy[k]}, 32'd0);
        chk("rst_write", {31'd0, pw[k]}, 32'd0);
        chk("rst_addr", {24'd0, pa[k]}, {24'd0, base_of(k)});
        chk("rst_data", pd[k], 32'd0);
        chk("rst_cpu_clr", {31'd0, cc[k]}, 32'd1);
        chk("rst_done", {31'd0, dn[k]}, 32'd0);
        chk("rst_error", {31'd0, er[k]}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycles %0d limit 100000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        clr[0]   = 1'b0;
        clr[1]   = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // 20080005 ^ 01095020 byte-wise XOR is 8'h55.
        fixed_bytes[0] = 8'h20; fixed_bytes[1] = 8'h08;
        fixed_bytes[2] = 8'h00; fixed_bytes[3] = 8'h05;
        fixed_bytes[4] = 8'h01; fixed_bytes[5] = 8'h09;
        fixed_bytes[6] = 8'h50; fixed_bytes[7] = 8'h20;

        //          k  cnt    gap bad done err cpu_clr
        tbl[0] = '{0, 8'h01, 0,  0,  1'b1, 1'b0, 1'b0};
        tbl[1] = '{0, 8'h03, 3,  1,  1'b0, 1'b1, 1'b1};
        tbl[2] = '{1, 8'h03, 2,  0,  1'b1, 1'b0, 1'b0};
        tbl[3] = '{0, 8'h00, 0,  0,  1'b1, 1'b0, 1'b0};
        tbl[4] = '{1, 8'h05, 1,  1,  1'b0, 1'b1, 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs(0);
        chk_reset_outputs(1);
        clr[0] = 1'b1;
        clr[1] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("idle_wait_ready0", {31'd0, rdy[0]}, 32'd0);
        chk("idle_wait_ready1", {31'd0, rdy[1]}, 32'd0);
        chk("idle_wait_write0", {31'd0, pw[0]}, 32'd0);

        // Basic load, then the same stream with checksum 5C (bad), then with stalls.
        run_load(0, 8'h02, 0, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);
        run_load(0, 8'h02, 0, 1'b1, 1'b1, -1, -1, 1'b0, 1'b1, 1'b1);
        run_load(0, 8'h02, 3, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);

        for (int i = 0; i < 5; i++) begin
            run_load(tbl[i].k, tbl[i].cnt, tbl[i].gap, tbl[i].bad, 1'b0, -1, -1,
                     tbl[i].exp_done, tbl[i].exp_err, tbl[i].exp_cc);
        end

        // Start pulsed while in DATA must not disturb the load; next load starts from DONE.
        run_load(0, 8'h02, 1, 1'b0, 1'b1, -1, 1, 1'b1, 1'b0, 1'b0);
        run_load(0, 8'h03, 0, 1'b0, 1'b0, -1, -1, 1'b1, 1'b0, 1'b0);

        // Reset asserted after the 6th data byte, between clock edges.
        run_load(0, 8'h02, 1, 1'b0, 1'b1, 6, -1, 1'b0, 1'b0, 1'b0);
        #2 clr[0] = 1'b0;
        #1;
        chk_reset_outputs(0);
        chk("abort_writes_pending", exp_q[0].size(), 32'd0);
        exp_q[0].delete();
        repeat (5) @(posedge clk);
        #1 clr[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("after_abort_idle", {31'd0, rdy[0]}, 32'd0);
        run_load(0, 8'h02, 0, 1'b0, 1'b1, -1, -1, 1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("final_pending0", exp_q[0].size(), 32'd0);
        chk("final_pending1", exp_q[1].size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
